// File: rtl/sram_mem_controller_if.sv
// Pipeline-side bus between the MEM stage and the off-chip SRAM controller.
interface sram_mem_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  ready;
    logic                  freeze;

    modport master (
        output Address, WriteData, MemRead, MemWrite,
        input  ReadData, ready, freeze
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite,
        output ReadData, ready, freeze
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Multi-cycle controller that splits each 32-bit MEM-stage access into two
// 16-bit SRAM accesses (low half, then high half) with programmable wait states.
module sram_mem_controller #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          SRAM_ADDR_WIDTH = 18,
    parameter int unsigned BASE_ADDR       = 1024,
    parameter int          WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_mem_controller_if.slave       bus,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH/2-1:0]    sram_dq_out,
    input  logic [DATA_WIDTH/2-1:0]    sram_dq_in,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n
);

    localparam int HALF_W = DATA_WIDTH / 2;
    localparam int OFF_W  = SRAM_ADDR_WIDTH - 1;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        is_wr_q, is_wr_d;
    logic [OFF_W-1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [HALF_W-1:0]           low_q, low_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                        ready_q, ready_d;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [HALF_W-1:0]           dq_q, dq_d;
    logic                        oe_q, oe_d;
    logic                        we_n_q, we_n_d;

    logic                        req;
    logic                        wait_done;
    logic [OFF_W-1:0]            off_in;

    assign req       = bus.MemRead | bus.MemWrite;
    assign wait_done = (cnt_q == CNT_W'(WAIT_CYCLES));
    // Byte-to-word offset; wraps modulo 2^32 and silently drops high bits.
    assign off_in    = OFF_W'((bus.Address - 32'(BASE_ADDR)) >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        low_d   = low_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        addr_d  = addr_q;
        dq_d    = dq_q;
        oe_d    = oe_q;
        we_n_d  = we_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    is_wr_d = bus.MemWrite;
                    off_d   = off_in;
                    wdata_d = bus.WriteData;
                    addr_d  = {off_in, 1'b0};
                    oe_d    = bus.MemWrite;
                    we_n_d  = ~bus.MemWrite;
                    if (bus.MemWrite) dq_d = bus.WriteData[HALF_W-1:0];
                end
            end
            LOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wait_done) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    addr_d  = {off_q, 1'b1};
                    if (is_wr_q) dq_d  = wdata_q[DATA_WIDTH-1:HALF_W];
                    else         low_d = sram_dq_in;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wait_done) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    if (!is_wr_q) rdata_d = {sram_dq_in, low_q};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request payload needs no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        is_wr_q <= is_wr_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
        low_q   <= low_d;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.freeze   = req & ~ready_q;
    assign sram_addr    = addr_q;
    assign sram_dq_out  = dq_q;
    assign sram_dq_oe   = oe_q;
    assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: transaction-level model plus
// hand-computed expectations, against a pulse-width-checking SRAM model.
module tb_sram_mem_controller;

    localparam int W     = 2;
    localparam int BASE  = 1024;
    localparam int KDONE = 2 * W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_mem_controller_if bus();
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_mem_controller dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: a write commits only after we_n is held low at one address for W+1 cycles.
    logic [15:0] sram [0:255];
    logic [17:0] s_prev = '0;
    int          s_len  = 0;
    assign sram_dq_in = sram[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            s_len  <= (sram_addr == s_prev) ? s_len + 1 : 1;
            s_prev <= sram_addr;
            if (((sram_addr == s_prev) ? s_len + 1 : 1) == W + 1)
                sram[sram_addr[7:0]] <= sram_dq_out;
        end else begin
            s_len <= 0;
        end
    end

    // Transaction model: k counts cycles since the request was accepted.
    logic [15:0] m_mem [0:255];
    bit          m_busy = 0, m_wr = 0, m_fresh = 1;
    int          m_k = 0;
    logic [16:0] m_off = '0;
    logic [31:0] m_data = '0;
    logic [7:0]  lo_i, hi_i;
    bit          in_low, in_high;
    logic        e_ready = 0, e_oe = 0, e_we_n = 1, e_addr_chk = 1;
    logic [31:0] e_rdata = '0;
    logic [17:0] e_addr = '0;
    logic [15:0] e_dq = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]  = '0;
            m_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 0;
            m_k     = 0;
            m_fresh = 1;
            e_rdata = '0;
        end else if (m_busy) begin
            lo_i = {m_off[6:0], 1'b0};
            hi_i = {m_off[6:0], 1'b1};
            if (m_k == W + 1 && m_wr) m_mem[lo_i] = m_data[15:0];
            if (m_k == 2 * W + 2) begin
                if (m_wr) m_mem[hi_i] = m_data[31:16];
                else      e_rdata = {m_mem[hi_i], m_mem[lo_i]};
            end
            if (m_k == KDONE) m_busy = 0;
            else              m_k++;
        end else if (bus.MemRead || bus.MemWrite) begin
            m_busy  = 1;
            m_k     = 1;
            m_fresh = 0;
            m_wr    = bus.MemWrite;
            m_off   = 17'((bus.Address - 32'(BASE)) >> 2);
            m_data  = bus.WriteData;
        end
        in_low     = m_busy && m_k <= W + 1;
        in_high    = m_busy && m_k >= W + 2 && m_k <= 2 * W + 2;
        e_ready    = m_busy && m_k == KDONE;
        e_addr_chk = in_low || in_high || m_fresh;
        e_addr     = m_fresh ? 18'd0 : {m_off, in_high};
        e_oe       = (in_low || in_high) && m_wr;
        e_we_n     = !e_oe;
        e_dq       = in_high ? m_data[31:16] : m_data[15:0];
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, bus.ready}, {31'd0, e_ready});
            check("freeze", {31'd0, bus.freeze},
                  {31'd0, (bus.MemRead | bus.MemWrite) & ~e_ready});
            check("we_n", {31'd0, sram_we_n}, {31'd0, e_we_n});
            check("dq_oe", {31'd0, sram_dq_oe}, {31'd0, e_oe});
            check("ReadData", bus.ReadData, e_rdata);
            if (e_addr_chk) check("sram_addr", {14'd0, sram_addr}, {14'd0, e_addr});
            if (e_oe)       check("dq_out", {16'd0, sram_dq_out}, {16'd0, e_dq});
        end
    end

    // One access; cycle 0 is the first cycle the request is presented.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input bit drop,
                          output int lat, output logic [31:0] rdat,
                          output logic [17:0] a_lo, output logic [17:0] a_hi,
                          output logic [15:0] dq_lo, output logic [15:0] dq_hi,
                          output logic we_lo);
        @(posedge clk); #1;
        bus.MemWrite  = wr;
        bus.MemRead   = rd;
        bus.Address   = a;
        bus.WriteData = d;
        lat = -1; rdat = 'x; a_lo = 'x; a_hi = 'x; dq_lo = 'x; dq_hi = 'x; we_lo = 'x;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 1) begin a_lo = sram_addr; dq_lo = sram_dq_out; we_lo = sram_we_n; end
            if (c == 4) begin a_hi = sram_addr; dq_hi = sram_dq_out; end
            if (bus.ready) begin
                lat  = c;
                rdat = bus.ReadData;
                break;
            end
        end
        if (drop) begin
            @(posedge clk); #1;
            bus.MemWrite = 1'b0;
            bus.MemRead  = 1'b0;
        end
    endtask

    int          lat, pulses;
    logic [31:0] rd;
    logic [17:0] alo, ahi;
    logic [15:0] dlo, dhi;
    logic        welo;

    initial begin
        bus.Address = '0; bus.WriteData = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        repeat (3) @(negedge clk);
        check("idle_ReadData", bus.ReadData, 32'h0);
        check("idle_ready", {31'd0, bus.ready}, 32'd0);
        check("idle_freeze", {31'd0, bus.freeze}, 32'd0);
        check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
        check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);

        access(1'b1, 1'b0, 32'd1024, 32'h0012_0034, 1'b1, lat, rd, alo, ahi, dlo, dhi, welo);
        check("wr_latency", lat, 32'd7);
        check("wr_addr_lo", {14'd0, alo}, 32'd0);
        check("wr_addr_hi", {14'd0, ahi}, 32'd1);
        check("wr_dq_lo", {16'd0, dlo}, 32'h0034);
        check("wr_dq_hi", {16'd0, dhi}, 32'h0012);
        check("wr_we_n_lo", {31'd0, welo}, 32'd0);

        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, lat, rd, alo, ahi, dlo, dhi, welo);
        check("rd_latency", lat, 32'd7);
        check("rd_data", rd, 32'h0012_0034);
        repeat (3) @(negedge clk);
        check("rd_hold", bus.ReadData, 32'h0012_0034);

        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, 32'(1024 + 4 * i), 32'(2 + i), i == 3,
                   lat, rd, alo, ahi, dlo, dhi, welo);
            check("seq_wr_latency", lat, 32'd7);
            check("seq_addr_lo", {14'd0, alo}, 32'(2 * i));
            check("seq_addr_hi", {14'd0, ahi}, 32'(2 * i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 32'(1024 + 4 * i), 32'h0, i == 3,
                   lat, rd, alo, ahi, dlo, dhi, welo);
            check("seq_rd", rd, 32'(2 + i));
        end

        access(1'b1, 1'b1, 32'd1026, 32'h0BAD_F00D, 1'b1, lat, rd, alo, ahi, dlo, dhi, welo);
        check("both_addr_lo", {14'd0, alo}, 32'd0);
        check("both_we_n", {31'd0, welo}, 32'd0);
        check("both_rdata_hold", rd, 32'd5);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, lat, rd, alo, ahi, dlo, dhi, welo);
        check("both_readback", rd, 32'h0BAD_F00D);

        @(posedge clk); #1;
        bus.MemWrite = 1'b1; bus.Address = 32'd1032; bus.WriteData = 32'hAAAA_BBBB;
        repeat (5) @(negedge clk);
        check("abort_in_high", {14'd0, sram_addr}, 32'd5);
        @(posedge clk); #1;
        rst = 1'b1; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("abort_ReadData", bus.ReadData, 32'h0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1, lat, rd, alo, ahi, dlo, dhi, welo);
        check("abort_readback", rd, 32'h0000_BBBB);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
